// File: rtl/painterengine_gpu_pkg.sv
// painterengine_gpu_pkg
//   Shared definitions for the GPU enable sequencer slice:
//   - seq_state_e : sequencer FSM states
//   - stage_w()   : width of a stage index for a given stage count (min 1)
package painterengine_gpu_pkg;

    typedef enum logic [2:0] {
        SEQ_SETTLE = 3'd0,
        SEQ_WAIT   = 3'd1,
        SEQ_GAP    = 3'd2,
        SEQ_DONE   = 3'd3,
        SEQ_ERROR  = 3'd4
    } seq_state_e;

    function automatic int stage_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/painterengine_gpu_delay_counter.sv
// painterengine_gpu_delay_counter
//   Up-counter shared by the sequencer's timed states.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : synchronous clear (wins over en)
//   en         : count enable
//   bound      : runtime terminal value
//   count      : current count
//   tc         : high while count == bound
module painterengine_gpu_delay_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] bound,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign count = cnt_q;
    assign tc    = (cnt_q == bound);

endmodule

// File: rtl/painterengine_gpu_enable_sequencer.sv
// painterengine_gpu_enable_sequencer
//   Power-up / restart sequencer for the GPU clock-enable tree. After a
//   settle window it raises one enable per stage, waits for that stage's
//   ready, waits an inter-stage gap, and moves on. Reports completion,
//   ready timeout, and post-completion ready dropout.
//   i_wire_clock / i_wire_reset : clock, synchronous active-high reset
//   i_wire_restart              : pulse, restart from settle
//   i_wire_ready                : per-stage ready level
//   o_wire_enable               : cumulative per-stage enables
//   o_wire_all_enabled          : all stages enabled and ready
//   o_wire_busy                 : sequencing in progress
//   o_wire_error                : sticky error
//   o_wire_error_stage          : stage that caused the error
module painterengine_gpu_enable_sequencer
    import painterengine_gpu_pkg::*;
#(
    parameter int NUM_STAGES     = 4,
    parameter int SETTLE_CYCLES  = 100,
    parameter int STAGE_GAP      = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic                                i_wire_clock,
    input  logic                                i_wire_reset,
    input  logic                                i_wire_restart,
    input  logic [NUM_STAGES-1:0]               i_wire_ready,
    output logic [NUM_STAGES-1:0]               o_wire_enable,
    output logic                                o_wire_all_enabled,
    output logic                                o_wire_busy,
    output logic                                o_wire_error,
    output logic [stage_w(NUM_STAGES)-1:0]      o_wire_error_stage
);

    localparam int SW = stage_w(NUM_STAGES);
    localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

    seq_state_e            state_d, state_q;
    logic [SW-1:0]         stage_d, stage_q;
    logic [NUM_STAGES-1:0] enable_d, enable_q;
    logic                  all_en_d, all_en_q;
    logic                  busy_d, busy_q;
    logic                  error_d, error_q;
    logic [SW-1:0]         err_stage_d, err_stage_q;

    logic                  cnt_clr, cnt_en, cnt_tc;
    logic [CNT_W-1:0]      cnt_bound, cnt_val;
    logic [SW-1:0]         next_stage;
    logic [SW-1:0]         drop_idx;

    assign next_stage = stage_q + 1'b1;

    // Lowest stage whose ready is low; only meaningful when ready != all ones.
    always_comb begin
        drop_idx = '0;
        for (int j = NUM_STAGES - 1; j >= 0; j--)
            if (!i_wire_ready[j])
                drop_idx = SW'(j);
    end

    painterengine_gpu_delay_counter #(.CNT_W(CNT_W)) u_delay (
        .clk   (i_wire_clock),
        .rst   (i_wire_reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .bound (cnt_bound),
        .count (cnt_val),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        enable_d    = enable_q;
        all_en_d    = all_en_q;
        busy_d      = busy_q;
        error_d     = error_q;
        err_stage_d = err_stage_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        cnt_bound   = '0;

        case (state_q)
            SEQ_SETTLE: begin
                cnt_bound = CNT_W'(SETTLE_CYCLES - 1);
                cnt_en    = 1'b1;
                if (cnt_tc) begin
                    enable_d[0] = 1'b1;
                    state_d     = SEQ_WAIT;
                    cnt_clr     = 1'b1;
                end
            end
            SEQ_WAIT: begin
                cnt_bound = CNT_W'(TIMEOUT_CYCLES - 1);
                cnt_en    = 1'b1;
                // Ready takes priority over the timeout terminal count.
                if (i_wire_ready[stage_q]) begin
                    cnt_clr = 1'b1;
                    if (stage_q == LAST_STAGE) begin
                        state_d  = SEQ_DONE;
                        all_en_d = 1'b1;
                        busy_d   = 1'b0;
                    end else begin
                        state_d = SEQ_GAP;
                    end
                end else if (cnt_tc) begin
                    cnt_clr     = 1'b1;
                    state_d     = SEQ_ERROR;
                    enable_d    = '0;
                    all_en_d    = 1'b0;
                    busy_d      = 1'b0;
                    error_d     = 1'b1;
                    err_stage_d = stage_q;
                end
            end
            SEQ_GAP: begin
                cnt_bound = CNT_W'(STAGE_GAP - 1);
                cnt_en    = 1'b1;
                if (cnt_tc) begin
                    enable_d[next_stage] = 1'b1;
                    stage_d              = next_stage;
                    state_d              = SEQ_WAIT;
                    cnt_clr              = 1'b1;
                end
            end
            SEQ_DONE: begin
                if (!(&i_wire_ready)) begin
                    state_d     = SEQ_ERROR;
                    enable_d    = '0;
                    all_en_d    = 1'b0;
                    busy_d      = 1'b0;
                    error_d     = 1'b1;
                    err_stage_d = drop_idx;
                end
            end
            default: ; // SEQ_ERROR holds until restart/reset
        endcase

        if (i_wire_restart) begin
            state_d     = SEQ_SETTLE;
            stage_d     = '0;
            enable_d    = '0;
            all_en_d    = 1'b0;
            busy_d      = 1'b1;
            error_d     = 1'b0;
            err_stage_d = '0;
            cnt_clr     = 1'b1;
            cnt_en      = 1'b0;
        end
    end

    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset) begin
            state_q     <= SEQ_SETTLE;
            stage_q     <= '0;
            enable_q    <= '0;
            all_en_q    <= 1'b0;
            busy_q      <= 1'b1;
            error_q     <= 1'b0;
            err_stage_q <= '0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            enable_q    <= enable_d;
            all_en_q    <= all_en_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
            err_stage_q <= err_stage_d;
        end
    end

    assign o_wire_enable      = enable_q;
    assign o_wire_all_enabled = all_en_q;
    assign o_wire_busy        = busy_q;
    assign o_wire_error       = error_q;
    assign o_wire_error_stage = err_stage_q;

endmodule

// File: tb/tb_painterengine_gpu_enable_sequencer.sv
module tb_painterengine_gpu_enable_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       restart = 1'b0;
    logic [3:0] ready = 4'hF;
    logic [3:0] enable;
    logic       all_en, busy, err;
    logic [1:0] err_stage;

    int checks = 0;
    int failures = 0;

    painterengine_gpu_enable_sequencer dut (
        .i_wire_clock       (clk),
        .i_wire_reset       (rst),
        .i_wire_restart     (restart),
        .i_wire_ready       (ready),
        .o_wire_enable      (enable),
        .o_wire_all_enabled (all_en),
        .o_wire_busy        (busy),
        .o_wire_error       (err),
        .o_wire_error_stage (err_stage)
    );

    always #10 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Snapshot: {error_stage, error, busy, all_enabled, enable}
    function automatic logic [31:0] snap();
        return {23'd0, err_stage, err, busy, all_en, enable};
    endfunction

    function automatic logic [31:0] exp_snap(input logic [1:0] es, input logic e,
                                             input logic b, input logic a,
                                             input logic [3:0] en);
        return {23'd0, es, e, b, a, en};
    endfunction

    initial begin
        // Reset state
        tick(3);
        check("reset_state", snap(), exp_snap(2'd0, 1'b0, 1'b1, 1'b0, 4'b0000));

        // 1: full sequence, all ready. Edges counted from reset release.
        rst = 1'b0;
        tick(99);
        check("s1_settle_e99", snap(), exp_snap(2'd0, 1'b0, 1'b1, 1'b0, 4'b0000));
        tick(1);   // edge 100
        check("s1_en0_e100", snap(), exp_snap(2'd0, 1'b0, 1'b1, 1'b0, 4'b0001));
        tick(16);  // edge 116
        check("s1_gap_e116", {28'd0, enable}, 32'h1);
        tick(1);   // edge 117
        check("s1_en1_e117", {28'd0, enable}, 32'h3);
        tick(17);  // edge 134
        check("s1_en2_e134", {28'd0, enable}, 32'h7);
        tick(16);  // edge 150
        check("s1_gap_e150", {28'd0, enable}, 32'h7);
        tick(1);   // edge 151
        check("s1_en3_e151", snap(), exp_snap(2'd0, 1'b0, 1'b1, 1'b0, 4'b1111));
        tick(1);   // edge 152
        check("s1_done_e152", snap(), exp_snap(2'd0, 1'b0, 1'b0, 1'b1, 4'b1111));

        // 2: ready[2] stuck low -> timeout
        rst = 1'b1; ready = 4'b1011;
        tick(1);
        rst = 1'b0;
        tick(134);
        check("s2_en2_e134", {28'd0, enable}, 32'h7);
        tick(1023); // edge 1157, 1023 WAIT edges
        check("s2_pre_timeout", snap(), exp_snap(2'd0, 1'b0, 1'b1, 1'b0, 4'b0111));
        tick(1);    // edge 1158, 1024th WAIT edge
        check("s2_timeout", snap(), exp_snap(2'd2, 1'b1, 1'b0, 1'b0, 4'b0000));
        tick(200);
        check("s2_error_held", snap(), exp_snap(2'd2, 1'b1, 1'b0, 1'b0, 4'b0000));

        // 3: restart from ERROR, full sequence again
        ready = 4'hF; restart = 1'b1;
        tick(1);
        restart = 1'b0;
        check("s3_restart", snap(), exp_snap(2'd0, 1'b0, 1'b1, 1'b0, 4'b0000));
        tick(99);
        check("s3_settle_99", {28'd0, enable}, 32'h0);
        tick(1);
        check("s3_en0_100", {28'd0, enable}, 32'h1);
        tick(51);
        check("s3_pre_done", snap(), exp_snap(2'd0, 1'b0, 1'b1, 1'b0, 4'b1111));
        tick(1);
        check("s3_done", snap(), exp_snap(2'd0, 1'b0, 1'b0, 1'b1, 4'b1111));

        // 4: dropout of ready[1] in DONE for one cycle
        ready = 4'b1101;
        tick(1);
        ready = 4'hF;
        check("s4_dropout", snap(), exp_snap(2'd1, 1'b1, 1'b0, 1'b0, 4'b0000));
        tick(5);
        check("s4_sticky", snap(), exp_snap(2'd1, 1'b1, 1'b0, 1'b0, 4'b0000));

        // 5: restart collides with first ready sample; restart held 3 edges
        restart = 1'b1;
        tick(3);
        restart = 1'b0;
        tick(100);
        check("s5_en0", {28'd0, enable}, 32'h1);
        restart = 1'b1;
        tick(1);   // would have been the first WAIT sample
        check("s5_restart_wins", snap(), exp_snap(2'd0, 1'b0, 1'b1, 1'b0, 4'b0000));
        restart = 1'b0;
        tick(99);
        check("s5_settle_99", {28'd0, enable}, 32'h0);
        tick(1);
        check("s5_en0_again", {28'd0, enable}, 32'h1);
        // If a GAP had been entered, enable[1] would already be high here
        tick(16);
        check("s5_no_stale_gap", {28'd0, enable}, 32'h1);

        // 6: reset mid-GAP after enable[1] rises (we are at rel edge 116)
        tick(1);   // rel edge 117
        check("s6_en1", {28'd0, enable}, 32'h3);
        tick(4);   // in GAP of stage 1
        rst = 1'b1;
        tick(1);
        check("s6_reset", snap(), exp_snap(2'd0, 1'b0, 1'b1, 1'b0, 4'b0000));
        rst = 1'b0;
        tick(99);
        check("s6_settle_99", {28'd0, enable}, 32'h0);
        tick(1);
        check("s6_en0_100", {28'd0, enable}, 32'h1);

        // Boundary: ready[2] arrives exactly on the timeout edge -> success
        rst = 1'b1; ready = 4'b1011;
        tick(1);
        rst = 1'b0;
        tick(134);
        tick(1023); // edge 1157
        ready = 4'hF;
        tick(1);    // edge 1158: ready sampled on timeout edge
        check("bnd_ready_on_timeout", snap(), exp_snap(2'd0, 1'b0, 1'b1, 1'b0, 4'b0111));
        tick(16);   // GAP of 16 edges -> enable[3]
        check("bnd_en3_after_gap", {28'd0, enable}, 32'hF);
        tick(1);
        check("bnd_done", snap(), exp_snap(2'd0, 1'b0, 1'b0, 1'b1, 4'b1111));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
